uart_intpt_ident: RTL

//  CPU-facing end of the UART interrupt path: prioritises pending sources, drives the IIR identification code,
//  and owns the sequential acknowledge/clear rules (THRE pending latch, character-timeout counter).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_intpt_ident_if.sv | 32 +++
 rtl/uart_char_tout_cnt.sv | 40 ++++
 rtl/uart_intpt_ident.sv | 80 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART interrupt identification path.
// IIR codes and the fixed source priority used by uart_intpt_ident.
package uart_pkg;

    typedef enum logic [3:0] {
        IIR_NONE = 4'b0001,
        IIR_RLS  = 4'b0110,
        IIR_RDA  = 4'b0100,
        IIR_CTI  = 4'b1100,
        IIR_THRE = 4'b0010
    } uart_iir_id_e;

    // Highest pending source wins; IIR_NONE when nothing is pending.
    function automatic uart_iir_id_e iir_prio(input logic rls, input logic rda,
                                              input logic cti, input logic thre_p);
        uart_iir_id_e id;
        id = IIR_NONE;
        if (rls)         id = IIR_RLS;
        else if (rda)    id = IIR_RDA;
        else if (cti)    id = IIR_CTI;
        else if (thre_p) id = IIR_THRE;
        return id;
    endfunction

endpackage

// File: rtl/uart_intpt_ident_if.sv
// Status/strobe bundle between the UART status logic, the CPU register file
// and the interrupt identification block.
interface uart_intpt_ident_if;
    logic       thre;
    logic       etbei;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       elsi;
    logic       dr;
    logic       erbi;
    logic       below_level;
    logic       rx_fifo_empty;
    logic       rx_activity;
    logic       char_tick;
    logic       iir_rd;
    logic       thr_wr;
    logic [3:0] iir_id;
    logic       uart_intpt;

    modport master (
        output thre, etbei, pe, fe, bi, elsi, dr, erbi, below_level,
               rx_fifo_empty, rx_activity, char_tick, iir_rd, thr_wr,
        input  iir_id, uart_intpt
    );

    modport slave (
        input  thre, etbei, pe, fe, bi, elsi, dr, erbi, below_level,
               rx_fifo_empty, rx_activity, char_tick, iir_rd, thr_wr,
        output iir_id, uart_intpt
    );
endinterface

// File: rtl/uart_char_tout_cnt.sv
// Character-timeout counter: counts char times of RX idle while the FIFO holds data.
// Exposes the next-cycle CTI pending flag so the IIR register sees it with one-cycle latency.
module uart_char_tout_cnt #(
    parameter int TOUT_CHARS = 4,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_rx_fifo_empty,
    input  logic i_rx_activity,
    input  logic i_erbi,
    input  logic i_char_tick,
    output logic o_cti_pend_nxt
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TOUT_CHARS);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hold;

    // Activity beats a coincident tick: the counter restarts from zero.
    assign w_hold = i_rx_fifo_empty | i_rx_activity | ~i_erbi;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_hold)
            w_cnt_nxt = '0;
        else if (i_char_tick && (r_cnt != TC))
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_cnt <= '0;
        else         r_cnt <= w_cnt_nxt;
    end

    assign o_cti_pend_nxt = (w_cnt_nxt == TC);

endmodule

// File: rtl/uart_intpt_ident.sv
// UART interrupt identification: prioritises sources, registers IIR[3:0] and the IRQ pin.
// Character timeout (CTI) is built only when UART_CHAR_TIMEOUT_EN is defined.
module uart_intpt_ident
    import uart_pkg::*;
#(
    parameter int TOUT_CHARS = 4,
    parameter int CNT_W      = 3
) (
    input  logic            clk,
    input  logic            arst_n,
    uart_intpt_ident_if.slave intf
);

    uart_iir_id_e r_iir_id;
    logic         r_intpt;
    logic         r_thre_pend;
    logic         r_thre_lvl_q;

    logic         w_thre_lvl;
    logic         w_thre_rise;
    logic         w_thre_clr;
    logic         w_thre_pend_nxt;
    logic         w_rls;
    logic         w_rda;
    logic         w_cti_pend_nxt;
    uart_iir_id_e w_iir_nxt;

`ifdef UART_CHAR_TIMEOUT_EN
    uart_char_tout_cnt #(
        .TOUT_CHARS (TOUT_CHARS),
        .CNT_W      (CNT_W)
    ) u_tout (
        .clk             (clk),
        .arst_n          (arst_n),
        .i_rx_fifo_empty (intf.rx_fifo_empty),
        .i_rx_activity   (intf.rx_activity),
        .i_erbi          (intf.erbi),
        .i_char_tick     (intf.char_tick),
        .o_cti_pend_nxt  (w_cti_pend_nxt)
    );
`else
    logic w_unused_tout;
    assign w_unused_tout  = &{1'b0, intf.rx_fifo_empty, intf.rx_activity, intf.char_tick};
    assign w_cti_pend_nxt = 1'b0;
`endif

    assign w_thre_lvl  = intf.thre & intf.etbei;
    assign w_thre_rise = w_thre_lvl & ~r_thre_lvl_q;
    // IIR read only acknowledges THRE if THRE is what the CPU actually saw.
    assign w_thre_clr  = intf.thr_wr | ~intf.etbei | (intf.iir_rd & (r_iir_id == IIR_THRE));

    always_comb begin
        w_thre_pend_nxt = r_thre_pend | w_thre_rise;
        if (w_thre_clr)
            w_thre_pend_nxt = 1'b0;
    end

    assign w_rls     = (intf.pe | intf.fe | intf.bi) & intf.elsi;
    assign w_rda     = intf.dr & intf.erbi & ~intf.below_level;
    assign w_iir_nxt = iir_prio(w_rls, w_rda, w_cti_pend_nxt & intf.erbi, w_thre_pend_nxt);

    // Level history resets high so a level still asserted across reset is not a fresh edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_thre_lvl_q <= 1'b1;
            r_thre_pend  <= 1'b0;
            r_iir_id     <= IIR_NONE;
            r_intpt      <= 1'b0;
        end else begin
            r_thre_lvl_q <= w_thre_lvl;
            r_thre_pend  <= w_thre_pend_nxt;
            r_iir_id     <= w_iir_nxt;
            r_intpt      <= (w_iir_nxt != IIR_NONE);
        end
    end

    assign intf.iir_id     = r_iir_id;
    assign intf.uart_intpt = r_intpt;

endmodule
